// File: rtl/up_counter.sv
// up_counter: free-running up-counter with sync clear/preset; `UP_COUNTER_TC_EN` adds the tc port
module up_counter #(
    parameter int unsigned           WIDTH        = 17,
    parameter logic [WIDTH-1:0]      MAX_COUNT    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]      PRESET_VALUE = MAX_COUNT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
`ifdef UP_COUNTER_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    // next count: clear beats preset, then wrap at the terminal value, else increment
    always_comb begin
        count_d = clr ? '0 :
                  pr ? PRESET_VALUE :
                  (count_q == MAX_COUNT) ? '0 : count_q + 1'b1;
    end
    // count register, updated every edge
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end
    assign out = count_q;
`ifdef UP_COUNTER_TC_EN
    // terminal-count decode from the register only, so it never sees the inputs
    always_comb begin
        tc = (count_q == MAX_COUNT);
    end
`endif
endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed checks of up_counter at default, 4-bit modulus-10 and 8-bit defaults
module tb_up_counter;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        pr  = 1'b0;
    logic [16:0] out;
    logic [3:0]  out4;
    logic [7:0]  out8;
    int          errors = 0;
    int          checks = 0;
`ifdef UP_COUNTER_TC_EN
    logic tc, tc4, tc8;
`endif

    always #5 clk = ~clk;

    up_counter dut (
        .clk(clk), .clr(clr), .pr(pr),
`ifdef UP_COUNTER_TC_EN
        .tc(tc),
`endif
        .out(out)
    );

    up_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .PRESET_VALUE(4'd3)) dut4 (
        .clk(clk), .clr(clr), .pr(pr),
`ifdef UP_COUNTER_TC_EN
        .tc(tc4),
`endif
        .out(out4)
    );

    up_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .pr(pr),
`ifdef UP_COUNTER_TC_EN
        .tc(tc8),
`endif
        .out(out8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        pr  = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        pr  = 1'b1;
        step();
        checks++;
        if (out !== 17'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++;
        if (out4 !== 4'd0) begin errors++; $display("FAIL reset_out4: got %0d expected 0", out4); end
        checks++;
        if (out8 !== 8'd0) begin errors++; $display("FAIL reset_out8: got %0d expected 0", out8); end
`ifdef UP_COUNTER_TC_EN
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0b expected 0", tc); end
`endif
        clr = 1'b0;
        pr  = 1'b0;
    endtask

    task automatic test_release();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (out !== 17'(i)) begin errors++; $display("FAIL release_%0d: got %0d expected %0d", i, out, i); end
        end
    endtask

    task automatic test_preset();
        do_reset();
        repeat (5) step();
        checks++;
        if (out !== 17'd5) begin errors++; $display("FAIL preset_pre: got %0d expected 5", out); end
        pr = 1'b1;
        step();
        pr = 1'b0;
        checks++;
        if (out !== 17'd131071) begin errors++; $display("FAIL preset_load: got %0d expected 131071", out); end
`ifdef UP_COUNTER_TC_EN
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL preset_tc: got %0b expected 1", tc); end
`endif
        step();
        checks++;
        if (out !== 17'd0) begin errors++; $display("FAIL preset_wrap: got %0d expected 0", out); end
`ifdef UP_COUNTER_TC_EN
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL preset_wrap_tc: got %0b expected 0", tc); end
`endif
        step();
        checks++;
        if (out !== 17'd1) begin errors++; $display("FAIL preset_after: got %0d expected 1", out); end
    endtask

    task automatic test_pr_held();
        do_reset();
        repeat (3) step();
        pr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out !== 17'd131071) begin errors++; $display("FAIL pr_held_%0d: got %0d expected 131071", i, out); end
            checks++;
            if (out4 !== 4'd3) begin errors++; $display("FAIL pr_held4_%0d: got %0d expected 3", i, out4); end
`ifdef UP_COUNTER_TC_EN
            checks++;
            if (tc !== 1'b1) begin errors++; $display("FAIL pr_held_tc_%0d: got %0b expected 1", i, tc); end
`endif
        end
        pr = 1'b0;
        step();
        checks++;
        if (out !== 17'd0) begin errors++; $display("FAIL pr_release: got %0d expected 0", out); end
        checks++;
        if (out4 !== 4'd4) begin errors++; $display("FAIL pr_release4: got %0d expected 4", out4); end
    endtask

    task automatic test_clr_held();
        do_reset();
        repeat (4) step();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pr = (i == 1);
            step();
            checks++;
            if (out !== 17'd0) begin errors++; $display("FAIL clr_held_%0d: got %0d expected 0", i, out); end
        end
        clr = 1'b0;
        pr  = 1'b0;
        step();
        checks++;
        if (out !== 17'd1) begin errors++; $display("FAIL clr_release: got %0d expected 1", out); end
    endtask

    task automatic test_mid_clear();
        do_reset();
        repeat (1000) step();
        checks++;
        if (out !== 17'd1000) begin errors++; $display("FAIL mid_count: got %0d expected 1000", out); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (out !== 17'd0) begin errors++; $display("FAIL mid_clear: got %0d expected 0", out); end
        step();
        checks++;
        if (out !== 17'd1) begin errors++; $display("FAIL mid_after: got %0d expected 1", out); end
    endtask

    task automatic test_small_modulus();
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            step();
            checks++;
            if (out4 !== 4'(i % 10)) begin errors++; $display("FAIL mod10_%0d: got %0d expected %0d", i, out4, i % 10); end
`ifdef UP_COUNTER_TC_EN
            checks++;
            if (tc4 !== (i % 10 == 9)) begin errors++; $display("FAIL mod10_tc_%0d: got %0b expected %0b", i, tc4, i % 10 == 9); end
`endif
        end
        pr = 1'b1;
        step();
        pr = 1'b0;
        checks++;
        if (out4 !== 4'd3) begin errors++; $display("FAIL mod10_pr: got %0d expected 3", out4); end
        step();
        checks++;
        if (out4 !== 4'd4) begin errors++; $display("FAIL mod10_pr_next: got %0d expected 4", out4); end
    endtask

    task automatic test_full_period8();
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            step();
            checks++;
            if (out8 !== 8'(i % 256)) begin errors++; $display("FAIL period8_%0d: got %0d expected %0d", i, out8, i % 256); end
        end
        pr = 1'b1;
        step();
        pr = 1'b0;
        checks++;
        if (out8 !== 8'd255) begin errors++; $display("FAIL period8_pr: got %0d expected 255", out8); end
        step();
        checks++;
        if (out8 !== 8'd0) begin errors++; $display("FAIL period8_pr_wrap: got %0d expected 0", out8); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_preset();
        test_pr_held();
        test_clr_held();
        test_mid_clear();
        test_small_modulus();
        test_full_period8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
